decode_hex_display: RTL

DECODE_HEX_DISPLAY -- requirements
Module: decode_hex_display

---
 rtl/decode_hex_display.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_hex_display.sv
// Recovers a hex byte from a scanned 7-segment display bus (marker, high digit, low digit).
// Inputs are synchronized and debounced, then a small FSM checks the glyph order and content.
module decode_hex_display #(
   parameter int unsigned settle_cycles  = 4,
   parameter int unsigned timeout_cycles = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] segments,
   input  logic [2:0] segments_enable,
   output logic [7:0] hex_byte,
   output logic       byte_valid,
   output logic       decode_error,
   output logic       sync_error,
   output logic       stale
);

   localparam logic [7:0]  SETTLE_MAX  = 8'(settle_cycles);
   localparam logic [31:0] TIMEOUT_MAX = 32'(timeout_cycles);
   localparam logic [7:0]  MARK_GLYPH  = 8'h2E;

   typedef enum logic [1:0] {
      WAIT_MARK = 2'd0,
      WAIT_HIGH = 2'd1,
      WAIT_LOW  = 2'd2
   } state_t;

   // Returns {legal, nibble}; only exact segment patterns are accepted.
   function automatic logic [4:0] glyph_decode(input logic [7:0] g);
      logic [4:0] r;
      case (g)
         8'hFC:   r = {1'b1, 4'h0};
         8'h60:   r = {1'b1, 4'h1};
         8'hDA:   r = {1'b1, 4'h2};
         8'hF2:   r = {1'b1, 4'h3};
         8'h66:   r = {1'b1, 4'h4};
         8'hB6:   r = {1'b1, 4'h5};
         8'hBE:   r = {1'b1, 4'h6};
         8'hE0:   r = {1'b1, 4'h7};
         8'hFE:   r = {1'b1, 4'h8};
         8'hF6:   r = {1'b1, 4'h9};
         8'hEE:   r = {1'b1, 4'hA};
         8'h3E:   r = {1'b1, 4'hB};
         8'h9C:   r = {1'b1, 4'hC};
         8'h7A:   r = {1'b1, 4'hD};
         8'h9E:   r = {1'b1, 4'hE};
         8'h8E:   r = {1'b1, 4'hF};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [2:0] e);
      return (e == 3'b001) || (e == 3'b010) || (e == 3'b100);
   endfunction

   logic [10:0] sync1_q, sync2_q, last_q;
   logic [7:0]  settle_q, settle_d;
   logic        sample_q, sample_d;
   logic [10:0] smp_q, smp_d;
   state_t      state_q, state_d;
   logic [3:0]  high_q, high_d;
   logic [7:0]  hex_q, hex_d;
   logic        bv_q, bv_d;
   logic        de_q, de_d;
   logic        se_q, se_d;
   logic [31:0] tmo_q, tmo_d;
   logic        stale_q, stale_d;
   logic        changed_s;
   logic [4:0]  dec_s;

   // Settle counter; a sample fires once, on the edge the counter first reaches its limit.
   always_comb begin
      changed_s = (sync2_q != last_q);
      if (changed_s) begin
         settle_d = 8'd0;
      end else if (settle_q == SETTLE_MAX) begin
         settle_d = settle_q;
      end else begin
         settle_d = settle_q + 8'd1;
      end
      sample_d = (settle_d == SETTLE_MAX) && (settle_q != SETTLE_MAX) && is_onehot(sync2_q[10:8]);
      if (sample_d) begin
         smp_d = sync2_q;
      end else begin
         smp_d = smp_q;
      end
   end

   // Frame FSM acting on the registered sample; errors are mutually exclusive by construction.
   always_comb begin
      state_d = state_q;
      high_d  = high_q;
      hex_d   = hex_q;
      bv_d    = 1'b0;
      de_d    = 1'b0;
      se_d    = 1'b0;
      dec_s   = glyph_decode(smp_q[7:0]);
      if (sample_q) begin
         case (smp_q[10:8])
            3'b001: begin
               if (smp_q[7:0] == MARK_GLYPH) begin
                  state_d = WAIT_HIGH;
                  se_d    = (state_q != WAIT_MARK);
               end else begin
                  state_d = WAIT_MARK;
                  de_d    = 1'b1;
               end
            end
            3'b100: begin
               if (state_q != WAIT_HIGH) begin
                  state_d = WAIT_MARK;
                  se_d    = 1'b1;
               end else if (dec_s[4]) begin
                  state_d = WAIT_LOW;
                  high_d  = dec_s[3:0];
               end else begin
                  state_d = WAIT_MARK;
                  de_d    = 1'b1;
               end
            end
            3'b010: begin
               if (state_q != WAIT_LOW) begin
                  state_d = WAIT_MARK;
                  se_d    = 1'b1;
               end else if (dec_s[4]) begin
                  state_d = WAIT_MARK;
                  hex_d   = {high_q, dec_s[3:0]};
                  bv_d    = 1'b1;
               end else begin
                  state_d = WAIT_MARK;
                  de_d    = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Timeout counter and stale flag; a new byte clears both on the same edge.
   always_comb begin
      if (bv_d) begin
         tmo_d = 32'd0;
      end else if (tmo_q == TIMEOUT_MAX) begin
         tmo_d = tmo_q;
      end else begin
         tmo_d = tmo_q + 32'd1;
      end
      if (bv_d) begin
         stale_d = 1'b0;
      end else if (tmo_d == TIMEOUT_MAX) begin
         stale_d = 1'b1;
      end else begin
         stale_d = stale_q;
      end
   end

   // All state, including the input synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 11'd0;
         sync2_q  <= 11'd0;
         last_q   <= 11'd0;
         settle_q <= 8'd0;
         sample_q <= 1'b0;
         smp_q    <= 11'd0;
         state_q  <= WAIT_MARK;
         high_q   <= 4'd0;
         hex_q    <= 8'd0;
         bv_q     <= 1'b0;
         de_q     <= 1'b0;
         se_q     <= 1'b0;
         tmo_q    <= 32'd0;
         stale_q  <= 1'b1;
      end else begin
         sync1_q  <= {segments_enable, segments};
         sync2_q  <= sync1_q;
         last_q   <= sync2_q;
         settle_q <= settle_d;
         sample_q <= sample_d;
         smp_q    <= smp_d;
         state_q  <= state_d;
         high_q   <= high_d;
         hex_q    <= hex_d;
         bv_q     <= bv_d;
         de_q     <= de_d;
         se_q     <= se_d;
         tmo_q    <= tmo_d;
         stale_q  <= stale_d;
      end
   end

   assign hex_byte     = hex_q;
   assign byte_valid   = bv_q;
   assign decode_error = de_q;
   assign sync_error   = se_q;
   assign stale        = stale_q;

endmodule
